addr_reg_bank: RTL and testbench

//  Parametrised address register file; successor of the fixed 8-bit AR/SP/PCpast/PC file.

---
 rtl/addr_reg_bank.sv | 126 ++++++++++++
 tb/tb_addr_reg_bank.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/addr_reg_bank.sv
// Parametrised address register file: NUM_REGS x WIDTH registers driven by one shared op code,
// with a bounded stack pointer (sticky overflow/underflow flags) and automatic PC-history capture.
module addr_reg_bank #(
  parameter int WIDTH       = 8,
  parameter int NUM_REGS    = 4,
  parameter int AR_IDX      = 0,
  parameter int SP_IDX      = 1,
  parameter int PCPAST_IDX  = 2,
  parameter int PC_IDX      = 3,
  parameter int SP_LO       = 0,
  parameter int SP_HI       = 2**WIDTH - 1,
  parameter bit AUTO_PCPAST = 1'b1,
  localparam int SEL_W      = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WIDTH-1:0]    Input,
  input  logic [NUM_REGS-1:0] RSel,
  input  logic [2:0]          FunSel,
  input  logic [SEL_W-1:0]    OASel,
  input  logic [SEL_W-1:0]    OBSel,
  input  logic                clr_flags,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic                sp_ovf,
  output logic                sp_unf
);

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;

  // Two guard bits so that max+1 and 0-1 stay exact and never alias across the bounds.
  localparam int XW = WIDTH + 2;
  localparam logic signed [XW-1:0] SP_LO_X = XW'(SP_LO);
  localparam logic signed [XW-1:0] SP_HI_X = XW'(SP_HI);
  localparam logic [WIDTH-1:0]     SP_RST  = SP_LO_X[WIDTH-1:0];

  if (NUM_REGS < 4 || AR_IDX == SP_IDX || AR_IDX == PC_IDX || AR_IDX == PCPAST_IDX ||
      SP_IDX == PC_IDX || SP_IDX == PCPAST_IDX || PC_IDX == PCPAST_IDX || SP_LO > SP_HI)
  begin : g_bad_params
    $error("addr_reg_bank: illegal register index or SP bound parameters");
  end

  logic [WIDTH-1:0]     regs     [NUM_REGS];
  logic [WIDTH-1:0]     regs_nxt [NUM_REGS];
  logic signed [XW-1:0] sp_old, in_sext, in_uext, sp_cand;
  logic                 op_writes, ovf_set, unf_set, pc_capture;

  assign op_writes  = (FunSel <= OP_ADD);
  assign pc_capture = AUTO_PCPAST && RSel[PC_IDX] && op_writes && !RSel[PCPAST_IDX];
  assign sp_old     = {2'b00, regs[SP_IDX]};
  assign in_uext    = {2'b00, Input};
  assign in_sext    = {{2{Input[WIDTH-1]}}, Input};

  // NOTE: every variable written in an always_comb gets a default on entry, so no path infers a latch.
  always_comb begin : sp_calc
    sp_cand = SP_LO_X;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (FunSel)
      OP_CLR:  sp_cand = SP_LO_X;
      OP_LOAD: sp_cand = in_uext;
      OP_DEC:  sp_cand = sp_old - XW'(1);
      OP_INC:  sp_cand = sp_old + XW'(1);
      OP_ADD:  sp_cand = sp_old + in_sext;
      default: sp_cand = sp_old;
    endcase
    if (RSel[SP_IDX] && op_writes) begin
      if (sp_cand > SP_HI_X)      ovf_set = 1'b1;
      else if (sp_cand < SP_LO_X) unf_set = 1'b1;
    end
  end

  always_comb begin : next_regs
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_nxt[i] = regs[i];
      if (RSel[i] && op_writes) begin
        if (i == SP_IDX) begin
          if (!ovf_set && !unf_set) regs_nxt[i] = sp_cand[WIDTH-1:0];
        end else begin
          case (FunSel)
            OP_CLR:  regs_nxt[i] = '0;
            OP_LOAD: regs_nxt[i] = Input;
            OP_DEC:  regs_nxt[i] = regs[i] - WIDTH'(1);
            OP_INC:  regs_nxt[i] = regs[i] + WIDTH'(1);
            OP_ADD:  regs_nxt[i] = regs[i] + Input;
            default: regs_nxt[i] = regs[i];
          endcase
        end
      end
    end
    // PCpast takes the pre-edge PC; an explicit op on PCpast suppresses this capture.
    if (pc_capture) regs_nxt[PCPAST_IDX] = regs[PC_IDX];
  end

  // NOTE: state is updated with non-blocking assignments so every register sees the old values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the bank is a few flops rather than a RAM, so every entry is reset explicitly.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == SP_IDX) regs[i] <= SP_RST;
        else             regs[i] <= '0;
      end
      sp_ovf <= 1'b0;
      sp_unf <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= regs_nxt[i];
      sp_ovf <= (sp_ovf & ~clr_flags) | ovf_set;
      sp_unf <= (sp_unf & ~clr_flags) | unf_set;
    end
  end

  // Out-of-range selects match no entry and read 0.
  always_comb begin : read_ports
    OutA = '0;
    OutB = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (OASel == SEL_W'(i)) OutA = regs[i];
      if (OBSel == SEL_W'(i)) OutB = regs[i];
    end
  end

endmodule

// File: tb/tb_addr_reg_bank.sv
// Self-checking bench for addr_reg_bank: a full-range and a bounded-SP instance share stimulus
// and are compared every cycle against an integer reference model.
module tb_addr_reg_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = '0;
  logic [3:0] rsel = '0;
  logic [2:0] fsel = '0;
  logic [1:0] oa = '0, ob = '0;
  logic       clr = 1'b0;
  logic [7:0] a_f, b_f, a_b, b_b;
  logic       ovf_f, unf_f, ovf_b, unf_b;

  int n_checks = 0;
  int n_errors = 0;

  int m  [2][4];
  int mo [2];
  int mu [2];
  int lo [2] = '{0, 16};
  int hi [2] = '{255, 31};

  always #20 clk = ~clk;

  addr_reg_bank dut_full (
    .clock(clk), .reset(reset), .Input(din), .RSel(rsel), .FunSel(fsel),
    .OASel(oa), .OBSel(ob), .clr_flags(clr),
    .OutA(a_f), .OutB(b_f), .sp_ovf(ovf_f), .sp_unf(unf_f)
  );

  addr_reg_bank #(.SP_LO(16), .SP_HI(31)) dut_bnd (
    .clock(clk), .reset(reset), .Input(din), .RSel(rsel), .FunSel(fsel),
    .OASel(oa), .OBSel(ob), .clr_flags(clr),
    .OutA(a_b), .OutB(b_b), .sp_ovf(ovf_b), .sp_unf(unf_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: registers as plain integers, SP bounds applied to the exact arithmetic result.
  task automatic model_step(input bit rst, input logic [3:0] rs, input int fs, input int inp,
                            input bit clr_in);
    int old [4];
    int v;
    bit so, su;
    for (int u = 0; u < 2; u++) begin
      old = m[u];
      so = 1'b0;
      su = 1'b0;
      if (rst) begin
        for (int i = 0; i < 4; i++) m[u][i] = (i == 1) ? lo[u] : 0;
        mo[u] = 0;
        mu[u] = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (rs[i] && fs <= 4) begin
            case (fs)
              0:       v = (i == 1) ? lo[u] : 0;
              1:       v = inp;
              2:       v = old[i] - 1;
              3:       v = old[i] + 1;
              default: v = old[i] + ((inp >= 128) ? inp - 256 : inp);
            endcase
            if (i == 1) begin
              if (v > hi[u])      so = 1'b1;
              else if (v < lo[u]) su = 1'b1;
              else                m[u][i] = v;
            end else begin
              m[u][i] = (v + 256) % 256;
            end
          end
        end
        if (rs[3] && fs <= 4 && !rs[2]) m[u][2] = old[3];
        mo[u] = (clr_in ? 0 : mo[u]) | int'(so);
        mu[u] = (clr_in ? 0 : mu[u]) | int'(su);
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      oa = 2'(i);
      ob = 2'(3 - i);
      #1;
      check($sformatf("full_A[%0d]", i), int'(a_f), m[0][i]);
      check($sformatf("full_B[%0d]", 3 - i), int'(b_f), m[0][3 - i]);
      check($sformatf("bnd_A[%0d]", i), int'(a_b), m[1][i]);
      check($sformatf("bnd_B[%0d]", 3 - i), int'(b_b), m[1][3 - i]);
    end
    check("full_ovf", int'(ovf_f), mo[0]);
    check("full_unf", int'(unf_f), mu[0]);
    check("bnd_ovf", int'(ovf_b), mo[1]);
    check("bnd_unf", int'(unf_b), mu[1]);
  endtask

  task automatic cycle(input bit rst, input logic [3:0] rs, input logic [2:0] fs,
                       input logic [7:0] inp, input bit clr_in);
    @(negedge clk);
    reset = rst;
    rsel  = rs;
    fsel  = fs;
    din   = inp;
    clr   = clr_in;
    @(posedge clk);
    #1;
    model_step(rst, rs, int'(fs), int'(inp), clr_in);
    reset = 1'b0;
    rsel  = '0;
    clr   = 1'b0;
    check_all();
  endtask

  task automatic read_pair(input logic [1:0] sa, input logic [1:0] sb);
    oa = sa;
    ob = sb;
    #1;
  endtask

  initial begin
    // Reset state: everything 0, bounded SP at its low bound.
    cycle(1'b1, 4'b0000, 3'b111, 8'h00, 1'b0);
    read_pair(2'd1, 2'd1);
    check("rst_full_sp", int'(a_f), 0);
    check("rst_bnd_sp", int'(b_b), 'h10);

    // PC load then increment: old PC auto-captured into PCpast.
    cycle(1'b0, 4'b1000, 3'b001, 8'h40, 1'b0);
    cycle(1'b0, 4'b1000, 3'b011, 8'h00, 1'b0);
    read_pair(2'd3, 2'd2);
    check("t1_pc", int'(a_f), 'h41);
    check("t1_pcpast", int'(b_f), 'h40);

    // AR wraps from FF to 00 without touching the flags.
    cycle(1'b0, 4'b0001, 3'b001, 8'hFF, 1'b0);
    cycle(1'b0, 4'b0001, 3'b011, 8'h00, 1'b0);
    read_pair(2'd0, 2'd0);
    check("t2_ar_wrap", int'(a_f), 0);
    check("t2_no_ovf", int'(ovf_f), 0);

    // Bounded SP at its high bound: increment blocked, sticky overflow.
    cycle(1'b0, 4'b0010, 3'b001, 8'h1F, 1'b0);
    cycle(1'b0, 4'b0010, 3'b011, 8'h00, 1'b0);
    read_pair(2'd1, 2'd1);
    check("t3_bnd_sp", int'(a_b), 'h1F);
    check("t3_bnd_ovf", int'(ovf_b), 1);
    check("t3_full_sp", int'(a_f), 'h20);

    // Bounded SP at its low bound: decrement blocked, sticky underflow.
    cycle(1'b0, 4'b0010, 3'b001, 8'h10, 1'b0);
    cycle(1'b0, 4'b0010, 3'b010, 8'h00, 1'b0);
    read_pair(2'd1, 2'd1);
    check("t4_bnd_sp", int'(a_b), 'h10);
    check("t4_bnd_unf", int'(unf_b), 1);

    // clr_flags with a legal op clears both flags.
    cycle(1'b0, 4'b0001, 3'b011, 8'h00, 1'b1);
    check("t5_ovf_clr", int'(ovf_b), 0);
    check("t5_unf_clr", int'(unf_b), 0);

    // clr_flags together with a new violation: the set wins.
    cycle(1'b0, 4'b0010, 3'b010, 8'h00, 1'b1);
    check("set_wins_unf", int'(unf_b), 1);

    // Signed add of -2 to AR and PCpast together; PC untouched.
    cycle(1'b0, 4'b0101, 3'b001, 8'h10, 1'b0);
    cycle(1'b0, 4'b0101, 3'b100, 8'hFE, 1'b0);
    read_pair(2'd0, 2'd2);
    check("t6_ar", int'(a_f), 'h0E);
    check("t6_pcpast", int'(b_f), 'h0E);
    read_pair(2'd3, 2'd3);
    check("t6_pc", int'(a_f), 'h41);

    // Reset overrides a simultaneous load.
    cycle(1'b1, 4'b1100, 3'b001, 8'h55, 1'b0);
    read_pair(2'd3, 2'd1);
    check("t7_pc", int'(a_f), 0);
    check("t7_bnd_sp", int'(b_b), 'h10);
    check("t7_unf", int'(unf_b), 0);

    // Randomised traffic, biased towards values near the bounded SP window.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r_in;
      r_in = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(14, 33)) : 8'($urandom);
      cycle(($urandom_range(0, 49) == 0), 4'($urandom), 3'($urandom), r_in,
            ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
